// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and latency helpers for the data-memory responder
//
// Contents:
//   stateT   responder FSM state (IDLE, BUSY, DONE)
//   opT      latched request kind (OP_RD, OP_WR)
//   CNT_W    width of the wait-state counter
//   LAT_MAX  largest latency the counter can express
//   latLegal true when a latency parameter fits the counter
//   latLoad  counter preload for a given latency
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } stateT;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } opT;

  localparam int CNT_W   = 4;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  function automatic logic latLegal(input int lat);
    return (lat >= 1) && (lat <= LAT_MAX);
  endfunction

  // The counter reaches zero on the edge that commits, so it starts one below the latency.
  function automatic logic [CNT_W-1:0] latLoad(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed single-port storage, falling-edge clocked
//
// Ports:
//   CLK      in   system clock, state updates on the falling edge
//   Reset_L  in   asynchronous active-low reset (read register only)
//   we       in   write enable, stores wdata at addr
//   re       in   read enable, loads rdata from addr
//   addr     in   word address
//   wdata    in   write data
//   rdata    out  registered read data, holds between reads
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset; only the output register is.
  logic [DATA_W-1:0] store [0:DEPTH-1];

  always_ff @(negedge CLK) begin
    if (we) begin
      store[addr] <= wdata;
    end
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= store[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle MEM-stage load/store responder with programmable wait states
//
// Ports:
//   CLK        in   system clock, all state updates on the falling edge
//   Reset_L    in   asynchronous active-low reset
//   mem_read   in   read request level, sampled while ready=1
//   mem_write  in   write request level, sampled while ready=1
//   addr       in   word address, sampled with the request
//   wdata      in   store data, sampled with a write request
//   ready      out  idle, a request can be accepted on the next edge
//   done       out  one-cycle pulse when a request completes
//   rdata      out  read data, valid while done=1 for a read, held otherwise
//   err        out  one-cycle pulse for a request with both read and write high
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  if (!latLegal(RD_LAT) || !latLegal(WR_LAT)) begin : gBadLat
    $error("dmem_responder: RD_LAT and WR_LAT must lie in 1..15");
  end

  localparam logic [CNT_W-1:0] RD_LOAD = latLoad(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = latLoad(WR_LAT);

  stateT             state;
  opT                opQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [CNT_W-1:0]  cnt;

  logic lastBusy;
  logic arrWe;
  logic arrRe;

  // The array sees the access only on the final BUSY edge, so a reset before that
  // edge leaves storage untouched and a committed write is visible to any later read.
  assign lastBusy = (state == BUSY) && (cnt == '0);
  assign arrWe    = lastBusy && (opQ == OP_WR);
  assign arrRe    = lastBusy && (opQ == OP_RD);

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uArray (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .we      (arrWe),
    .re      (arrRe),
    .addr    (addrQ),
    .wdata   (wdataQ),
    .rdata   (rdata)
  );

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= IDLE;
      opQ    <= OP_RD;
      addrQ  <= '0;
      wdataQ <= '0;
      cnt    <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // done and err are pulses; each branch raises them for one cycle only.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read && mem_write) begin
            err <= 1'b1;
          end else if (mem_read || mem_write) begin
            opQ    <= mem_write ? OP_WR : OP_RD;
            addrQ  <= addr;
            wdataQ <= wdata;
            cnt    <= mem_write ? WR_LOAD : RD_LOAD;
            ready  <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
